// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption core, one round per clock.
// The core latches the whole round-key schedule when it accepts a block, so
// the upstream key-expansion chain is free as soon as the handshake completes.
// Byte b of every 128-bit word sits at bits [127-8b -: 8]. The state is
// column-major, so byte b is at column b/4 and row b%4.
`timescale 1ns/1ps
module aes_enc_iter #(
   parameter int NUM_ROUNDS = 10,   // AES-128 only
   parameter int BLK_W      = 128   // fixed block width
) (
   input  logic                            clk,
   input  logic                            i_reset_n,
   input  logic                            i_valid,
   output logic                            o_ready,
   input  logic [BLK_W-1:0]                i_block,
   input  logic [BLK_W*(NUM_ROUNDS+1)-1:0] i_key_schedule,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [BLK_W-1:0]                o_block
);

   localparam int KS_W = BLK_W * (NUM_ROUNDS + 1);

   // Forward S-box. Entry a is stored at bits [8*(255-a) +: 8].
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUND,
      S_DONE
   } state_t;

   function automatic logic [7:0] f_sbox(input logic [7:0] i_a);
      f_sbox = SBOX_TBL[{~i_a, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] f_xtime(input logic [7:0] i_a);
      f_xtime = {i_a[6:0], 1'b0} ^ (i_a[7] ? 8'h1B : 8'h00);
   endfunction

   // SubBytes followed by ShiftRows. Row r rotates left by r columns.
   function automatic logic [127:0] f_sub_shift(input logic [127:0] i_st);
      logic [127:0] v_out;
      v_out = '0;
      for (int b = 0; b < 16; b++) begin
         int v_row;
         int v_col;
         int v_src;
         v_row = b % 4;
         v_col = b / 4;
         v_src = v_row + 4 * ((v_col + v_row) % 4);
         v_out[127-8*b -: 8] = f_sbox(i_st[127-8*v_src -: 8]);
      end
      f_sub_shift = v_out;
   endfunction

   function automatic logic [31:0] f_mix_col(input logic [31:0] i_col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = i_col;
      f_mix_col = {f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3,
                   a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3,
                   a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3,
                   f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3)};
   endfunction

   function automatic logic [127:0] f_mix_columns(input logic [127:0] i_st);
      logic [127:0] v_out;
      v_out = '0;
      for (int c = 0; c < 4; c++) begin
         v_out[127-32*c -: 32] = f_mix_col(i_st[127-32*c -: 32]);
      end
      f_mix_columns = v_out;
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_rnd;
   logic [127:0]     r_st;
   logic [KS_W-1:0]  r_ks;
   logic [127:0]     r_out;
   logic             r_ready;
   logic             r_valid;

   logic             w_accept;
   logic             w_last;
   logic             w_handoff;
   logic [127:0]     w_sub_shift;
   logic [127:0]     w_mix;
   logic [127:0]     w_rk;

   // Round datapath: the final round skips MixColumns.
   assign w_sub_shift = f_sub_shift(r_st);
   assign w_mix       = f_mix_columns(w_sub_shift);
   assign w_rk        = r_ks[{r_rnd, 7'b000_0000} +: 128];

   // Next-state and handshake decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      w_handoff   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_valid && r_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = S_ROUND;
            end
         end
         S_ROUND: begin
            if (r_rnd == 4'(NUM_ROUNDS)) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (r_valid && i_ready) begin
               w_handoff   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Round state, latched key copy, round counter and the registered handshake.
   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         // NOTE: the latched key schedule is a plain register bank, so it is cleared like the rest of the state.
         r_ks    <= '0;
         r_st    <= '0;
         r_out   <= '0;
         r_rnd   <= '0;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_ks    <= i_key_schedule;
            r_st    <= i_block ^ i_key_schedule[127:0];
            r_rnd   <= 4'd1;
            r_ready <= 1'b0;
         end
         if (r_state == S_ROUND) begin
            if (w_last) begin
               r_out   <= w_sub_shift ^ w_rk;
               r_valid <= 1'b1;
               r_rnd   <= 4'd0;
            end else begin
               r_st  <= w_mix ^ w_rk;
               r_rnd <= r_rnd + 4'd1;
            end
         end
         if (w_handoff) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
         end
      end
   end

   assign o_ready = r_ready;
   assign o_valid = r_valid;
   assign o_block = r_out;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Testbench for aes_enc_iter. It builds its own S-box from the GF(2^8) inverse
// and the affine map, expands keys with the FIPS-197 key schedule, and checks
// ciphertexts through a scoreboard queue. A monitor pops and compares on each
// output handoff and also checks accept-to-valid latency.
`timescale 1ns/1ps
module tb_aes_enc_iter;

   logic            clk;
   logic            i_reset_n;
   logic            i_valid;
   logic            o_ready;
   logic [127:0]    i_block;
   logic [1407:0]   i_key_schedule;
   logic            o_valid;
   logic            i_ready;
   logic [127:0]    o_block;

   aes_enc_iter dut (
      .clk            (clk),
      .i_reset_n      (i_reset_n),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_block        (i_block),
      .i_key_schedule (i_key_schedule),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_block        (o_block)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;
   logic [127:0]  exp_q[$];
   int            acc_q[$];
   int            acc_hist[$];
   logic [7:0]    sb[256];
   bit            rand_ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x};
      return d[15-n -: 8];
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [1407:0] expand_key(input logic [127:0] key);
      logic [31:0]   w[44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1407:0] ks;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = gf_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return ks;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1407:0] ks);
      logic [7:0]   s[16];
      logic [7:0]   t[16];
      logic [127:0] out;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
               s[row + 4*col] = t[row + 4*((col + row) % 4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               logic [7:0] a0, a1, a2, a3;
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
               s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[128*r + 127 - 8*i -: 8];
      end
      for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
      return out;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      if (i_reset_n) begin
         check(!(o_valid && o_ready), "ready_valid_exclusive", {126'd0, o_valid, o_ready}, 128'd0);
         if (i_valid && o_ready) begin
            acc_q.push_back(cyc + 1);
            acc_hist.push_back(cyc + 1);
         end
         if (o_valid && !prev_valid) begin
            if (acc_q.size() == 0) begin
               check(1'b0, "valid_without_accept", o_block, 128'd0);
            end else begin
               int a;
               a = acc_q.pop_front();
               check(cyc - a == 10, "latency", 128'(cyc - a), 128'd10);
            end
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_output", o_block, 128'd0);
            end else begin
               logic [127:0] e;
               e = exp_q.pop_front();
               check(o_block == e, "ciphertext", o_block, e);
            end
         end
      end
      prev_valid = o_valid;
   end

   // Random downstream backpressure during the random phase.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ready) i_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- driver ----------------
   task automatic send(input logic [127:0] blk, input logic [1407:0] ks, input logic [127:0] exp, input bit scramble);
      int n;
      logic [1407:0] junk;
      exp_q.push_back(exp);
      i_block        = blk;
      i_key_schedule = ks;
      i_valid        = 1'b1;
      n = 0;
      @(negedge clk);
      while (!o_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(n < 200, "accept_timeout", 128'(n), 128'd200);
      @(posedge clk); #1;
      if (scramble) begin
         repeat (5) begin
            i_block = rand128();
            for (int w = 0; w < 44; w++) junk[32*w +: 32] = $urandom();
            i_key_schedule = junk;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !o_ready) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(n < 400, "drain_timeout", 128'(exp_q.size()), 128'd0);
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] H_B   = 128'h7df76b0c1ab899b33e42f047b91b546f;

   initial begin
      logic [1407:0] ks_b, ks_c, ks_r;
      logic [127:0]  key_r, pt_r, hold;
      int            base, n;

      i_reset_n      = 1'b0;
      i_valid        = 1'b1;
      i_ready        = 1'b1;
      i_block        = rand128();
      i_key_schedule = '1;
      build_sbox();
      ks_b = expand_key(KEY_B);
      ks_c = expand_key(KEY_C);

      // Reset state, with i_valid asserted to show reset wins.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(o_ready == 1'b1, "reset_o_ready", 128'(o_ready), 128'd1);
      check(o_valid == 1'b0, "reset_o_valid", 128'(o_valid), 128'd0);
      check(o_block == 128'd0, "reset_o_block", o_block, 128'd0);
      @(posedge clk); #1;
      i_valid   = 1'b0;
      i_reset_n = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 App.B, C.1 and the GCM hash subkey.
      send(PT_B, ks_b, CT_B, 1'b0);
      i_valid = 1'b0;
      wait_idle();
      send(PT_C, ks_c, CT_C, 1'b0);
      i_valid = 1'b0;
      wait_idle();
      send(128'd0, ks_b, H_B, 1'b0);
      i_valid = 1'b0;
      wait_idle();

      // Backpressure: output held for 20 stalled cycles.
      i_ready = 1'b0;
      send(PT_B, ks_b, CT_B, 1'b0);
      i_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!o_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(n < 50, "stall_valid_timeout", 128'(n), 128'd50);
      hold = o_block;
      repeat (20) begin
         @(negedge clk);
         check(o_valid && !o_ready && o_block == hold, "stall_hold", o_block, hold);
      end
      @(posedge clk); #1;
      i_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check(!o_valid && o_ready, "post_handoff", {126'd0, o_valid, o_ready}, 128'd1);
      @(posedge clk); #1;
      wait_idle();

      // Back-to-back with i_valid held high and inputs scrambled mid-block.
      base = acc_hist.size();
      for (int k = 0; k < 3; k++) begin
         key_r = rand128();
         pt_r  = rand128();
         ks_r  = expand_key(key_r);
         send(pt_r, ks_r, aes_ref(pt_r, ks_r), 1'b1);
      end
      i_valid = 1'b0;
      wait_idle();
      if (acc_hist.size() >= base + 3) begin
         check(acc_hist[base+1] - acc_hist[base] == 12, "accept_spacing_1", 128'(acc_hist[base+1] - acc_hist[base]), 128'd12);
         check(acc_hist[base+2] - acc_hist[base+1] == 12, "accept_spacing_2", 128'(acc_hist[base+2] - acc_hist[base+1]), 128'd12);
      end else begin
         check(1'b0, "accept_count", 128'(acc_hist.size() - base), 128'd3);
      end

      // Reset during round 5 aborts the block.
      send(PT_C, ks_c, CT_C, 1'b0);
      i_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      i_reset_n = 1'b0;
      exp_q.delete();
      acc_q.delete();
      @(posedge clk); #1;
      i_reset_n = 1'b1;
      @(negedge clk);
      check(o_valid == 1'b0, "abort_o_valid", 128'(o_valid), 128'd0);
      check(o_ready == 1'b1, "abort_o_ready", 128'(o_ready), 128'd1);
      check(o_block == 128'd0, "abort_o_block", o_block, 128'd0);
      @(posedge clk); #1;
      send(PT_B, ks_b, CT_B, 1'b0);
      i_valid = 1'b0;
      wait_idle();

      // Random keys and blocks against the reference model, random backpressure.
      rand_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         key_r = rand128();
         pt_r  = rand128();
         ks_r  = expand_key(key_r);
         send(pt_r, ks_r, aes_ref(pt_r, ks_r), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            i_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk); #1;
            end
         end
      end
      i_valid = 1'b0;
      rand_ready = 1'b0;
      i_ready = 1'b1;
      wait_idle();
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
